// File: rtl/Falco_pkg.sv
// Falco shared types for the execute/writeback stage.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package Falco_pkg;

  localparam int PRF_ADDR_W = 6;
  localparam int XLEN       = 32;

  typedef logic [PRF_ADDR_W-1:0] prf_specifier_t;
  typedef logic [XLEN-1:0]       xlen_data_t;

  typedef struct packed {
    logic           valid;
    prf_specifier_t wb_addr;
    xlen_data_t     wb_data;
  } exe_fu_wb_t;

  localparam int WB_NUM_REQ = 4;
  localparam int WB_NUM_WP  = 2;

  typedef enum logic [1:0] {
    WB_ALU_CSR_BC = 2'd0,
    WB_ALU1       = 2'd1,
    WB_MULDIV     = 2'd2,
    WB_MEM        = 2'd3
  } wb_req_e;

  // Pointer width for an n-entry round-robin ring; never zero so ports stay legal.
  function automatic int wb_ptr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_multi_grant.sv
// Round-robin picker granting up to NUM_WP occupied slots, scanning from rr_ptr with wrap.
// Latency: purely combinational.
// Backpressure: none; slots not granted simply stay occupied for a later cycle.
module rr_multi_grant
  import Falco_pkg::*;
#(
  parameter int NUM_REQ = WB_NUM_REQ,
  parameter int NUM_WP  = WB_NUM_WP,
  parameter int PTR_W   = wb_ptr_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] occ,
  input  logic [PTR_W-1:0]   rr_ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [PTR_W-1:0]   port_idx [NUM_WP],
  output logic [NUM_WP-1:0]  port_vld,
  output logic [PTR_W-1:0]   next_ptr
);

  // Walk the ring once starting at rr_ptr; the k-th occupied slot found takes port k.
  always_comb begin
    int cnt;
    int idx;
    grant    = '0;
    port_vld = '0;
    next_ptr = rr_ptr;
    for (int k = 0; k < NUM_WP; k++) begin
      port_idx[k] = '0;
    end
    cnt = 0;
    idx = 0;
    for (int off = 0; off < NUM_REQ; off++) begin
      idx = (int'(rr_ptr) + off) % NUM_REQ;
      if (occ[idx] && (cnt < NUM_WP)) begin
        grant[idx]    = 1'b1;
        port_idx[cnt] = PTR_W'(idx);
        port_vld[cnt] = 1'b1;
        // Resume after the last winner so it drops to lowest priority next cycle.
        next_ptr      = PTR_W'((idx + 1) % NUM_REQ);
        cnt           = cnt + 1;
      end
    end
  end

endmodule

// File: rtl/prf_wb_arbiter.sv
// Shares NUM_WP PRF write ports among NUM_REQ FU result streams via one-entry buffers.
// Latency: result accepted at edge E drives wp_wb during the following cycle (written at E+1).
// Backpressure: req_ready low while a buffer is occupied and not granted this cycle.
module prf_wb_arbiter
  import Falco_pkg::*;
#(
  parameter int NUM_REQ = WB_NUM_REQ,
  parameter int NUM_WP  = WB_NUM_WP,
  parameter int CNT_W   = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req_valid,
  input  exe_fu_wb_t         req_wb [NUM_REQ],
  output logic [NUM_REQ-1:0] req_ready,
  output exe_fu_wb_t         wp_wb [NUM_WP],
  output logic [CNT_W-1:0]   stall_cnt
);

  localparam int PTR_W = wb_ptr_w(NUM_REQ);

  logic [NUM_REQ-1:0] occ;
  prf_specifier_t     buf_addr [NUM_REQ];
  xlen_data_t         buf_data [NUM_REQ];
  logic [PTR_W-1:0]   rr_ptr;

  logic [NUM_REQ-1:0] arb_occ;
  logic [NUM_REQ-1:0] grant;
  logic [PTR_W-1:0]   port_idx [NUM_WP];
  logic [NUM_WP-1:0]  port_vld;
  logic [PTR_W-1:0]   next_ptr;
  logic [NUM_REQ-1:0] accept;
  logic               stall;

  // The payload's own valid bit is redundant with req_valid.
  logic [NUM_REQ-1:0] unused_payload_valid;

  // Hide the buffers while reset is held so nothing is written or granted.
  assign arb_occ = rst ? '0 : occ;

  rr_multi_grant #(
    .NUM_REQ (NUM_REQ),
    .NUM_WP  (NUM_WP),
    .PTR_W   (PTR_W)
  ) u_rr (
    .occ      (arb_occ),
    .rr_ptr   (rr_ptr),
    .grant    (grant),
    .port_idx (port_idx),
    .port_vld (port_vld),
    .next_ptr (next_ptr)
  );

  // A buffer can take a new result if empty or draining this cycle.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      req_ready[i]            = !rst && (!occ[i] || grant[i]);
      unused_payload_valid[i] = req_wb[i].valid;
    end
  end

  assign accept = req_valid & req_ready;
  assign stall  = |(arb_occ & ~grant);

  // Route each granted buffer to its port; idle ports read as all zero.
  always_comb begin
    for (int k = 0; k < NUM_WP; k++) begin
      wp_wb[k] = '0;
      if (port_vld[k]) begin
        wp_wb[k].valid   = 1'b1;
        wp_wb[k].wb_addr = buf_addr[port_idx[k]];
        wp_wb[k].wb_data = buf_data[port_idx[k]];
      end
    end
  end

  // Occupancy, round-robin pointer and saturating stall counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      occ       <= '0;
      rr_ptr    <= '0;
      stall_cnt <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        // x0 results complete the handshake but never occupy a buffer.
        if (accept[i] && (req_wb[i].wb_addr != '0)) begin
          occ[i] <= 1'b1;
        end else if (grant[i]) begin
          occ[i] <= 1'b0;
        end
      end
      if (|port_vld) begin
        rr_ptr <= next_ptr;
      end
      if (stall && (stall_cnt != '1)) begin
        stall_cnt <= stall_cnt + CNT_W'(1);
      end
    end
  end

  // Buffer payload; only meaningful while occ is set, so no reset needed.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_REQ; i++) begin
      if (accept[i] && (req_wb[i].wb_addr != '0)) begin
        buf_addr[i] <= req_wb[i].wb_addr;
        buf_data[i] <= req_wb[i].wb_data;
      end
    end
  end

  // Renaming guarantees distinct destinations among simultaneous writes.
  for (genvar a = 0; a < NUM_WP; a++) begin : g_dup_a
    for (genvar b = a + 1; b < NUM_WP; b++) begin : g_dup_b
      a_unique_dest : assert property (@(posedge clk) disable iff (rst)
        !(wp_wb[a].valid && wp_wb[b].valid && (wp_wb[a].wb_addr == wp_wb[b].wb_addr)));
    end
  end

endmodule

// File: tb/tb_prf_wb_arbiter.sv
// Bench for prf_wb_arbiter: directed scenarios plus randomized traffic against a queue-based model.
// Latency: n/a.
// Backpressure: requesters hold valid and payload until accepted.
module tb_prf_wb_arbiter;
  import Falco_pkg::*;

  localparam int  NR   = 4;
  localparam int  NW   = 2;
  localparam int  CW   = 5;
  localparam int  CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic [NR-1:0] req_valid;
  exe_fu_wb_t    req_wb [NR];
  logic [NR-1:0] req_ready;
  exe_fu_wb_t    wp_wb [NW];
  logic [CW-1:0] stall_cnt;

  always #5 clk = ~clk;

  prf_wb_arbiter #(.NUM_REQ(NR), .NUM_WP(NW), .CNT_W(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_wb    (req_wb),
    .req_ready (req_ready),
    .wp_wb     (wp_wb),
    .stall_cnt (stall_cnt)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: what each FU has parked, a ring pointer, and the stall count.
  bit         m_occ [NR];
  exe_fu_wb_t m_buf [NR];
  int         m_ptr;
  int         m_cnt;
  bit         last_acc [NR];
  int         gq [$];
  bit         gbit [NR];

  function automatic exe_fu_wb_t mk(input int addr, input logic [31:0] data);
    exe_fu_wb_t w;
    w.valid   = 1'b1;
    w.wb_addr = prf_specifier_t'(addr);
    w.wb_data = data;
    return w;
  endfunction

  // Winners this cycle: the first NW parked results met going round from m_ptr.
  function automatic void arb();
    gq.delete();
    for (int i = 0; i < NR; i++) gbit[i] = 1'b0;
    if (rst) return;
    for (int off = 0; off < NR; off++) begin
      int i;
      i = (m_ptr + off) % NR;
      if (m_occ[i] && gq.size() < NW) begin
        gq.push_back(i);
        gbit[i] = 1'b1;
      end
    end
  endfunction

  task automatic check_outputs();
    logic [NR-1:0] er;
    exe_fu_wb_t    ep;
    arb();
    for (int i = 0; i < NR; i++) er[i] = !rst && (!m_occ[i] || gbit[i]);
    check("req_ready", 64'(req_ready), 64'(er));
    for (int k = 0; k < NW; k++) begin
      ep = '0;
      if (k < gq.size()) ep = m_buf[gq[k]];
      check($sformatf("wp_wb%0d", k), 64'(wp_wb[k]), 64'(ep));
    end
    check("stall_cnt", 64'(stall_cnt), 64'(m_cnt));
  endtask

  task automatic model_edge();
    bit st;
    bit acc;
    arb();
    if (rst) begin
      for (int i = 0; i < NR; i++) begin
        m_occ[i]    = 1'b0;
        last_acc[i] = 1'b0;
      end
      m_ptr = 0;
      m_cnt = 0;
      return;
    end
    st = 1'b0;
    for (int i = 0; i < NR; i++) if (m_occ[i] && !gbit[i]) st = 1'b1;
    if (st && m_cnt < CMAX) m_cnt++;
    if (gq.size() > 0) m_ptr = (gq[gq.size()-1] + 1) % NR;
    for (int i = 0; i < NR; i++) begin
      acc         = req_valid[i] && (!m_occ[i] || gbit[i]);
      last_acc[i] = acc;
      if (acc && req_wb[i].wb_addr != 0) begin
        m_occ[i] = 1'b1;
        m_buf[i] = req_wb[i];
      end else if (gbit[i]) begin
        m_occ[i] = 1'b0;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_outputs();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int seq;
    seq = 0;
    m_ptr = 0;
    m_cnt = 0;
    for (int i = 0; i < NR; i++) begin
      m_occ[i]    = 1'b0;
      last_acc[i] = 1'b0;
      m_buf[i]    = '0;
    end

    // Reset with every FU offering.
    rst       = 1'b1;
    req_valid = '1;
    for (int i = 0; i < NR; i++) req_wb[i] = mk(30 + i, 32'h100 + i);
    repeat (3) tick();
    check("rst_ready", 64'(req_ready), 64'h0);
    rst       = 1'b0;
    req_valid = '0;
    #1;
    check("ready_after_rst", 64'(req_ready), 64'hF);

    // Full contention: addrs 10..13 every cycle; also drives the counter into saturation.
    req_valid = '1;
    for (int i = 0; i < NR; i++) req_wb[i] = mk(10 + i, 32'hA0 + i);
    tick();
    check("fc_c1_p0", 64'(wp_wb[0].wb_addr), 64'd10);
    check("fc_c1_p1", 64'(wp_wb[1].wb_addr), 64'd11);
    tick();
    check("fc_c2_p0", 64'(wp_wb[0].wb_addr), 64'd12);
    check("fc_c2_p1", 64'(wp_wb[1].wb_addr), 64'd13);
    repeat (38) tick();
    check("stall_sat", 64'(stall_cnt), 64'(CMAX));
    req_valid = '0;
    repeat (3) tick();

    // Single requester: muldiv only.
    req_valid = 4'b0100;
    req_wb[2] = mk(7, 32'hDEADBEEF);
    tick();
    req_valid = '0;
    check("single_p0", 64'(wp_wb[0]), 64'(mk(7, 32'hDEADBEEF)));
    check("single_p1", 64'(wp_wb[1]), 64'h0);
    tick();

    // x0 drop from mem.
    req_valid = 4'b1000;
    req_wb[3] = mk(0, 32'h1234);
    #1;
    check("x0_ready", 64'(req_ready[3]), 64'd1);
    tick();
    req_valid = '0;
    check("x0_no_write", 64'(wp_wb[0].valid), 64'd0);
    tick();

    // Back-to-back refill on alu1.
    for (int a = 20; a <= 22; a++) begin
      req_valid = 4'b0010;
      req_wb[1] = mk(a, 32'h5000 + a);
      tick();
      check($sformatf("b2b_%0d", a), 64'(wp_wb[0].wb_addr), 64'(a));
    end
    req_valid = '0;
    tick();

    // Reset mid-flight with three buffers occupied.
    req_valid = 4'b0111;
    for (int i = 0; i < 3; i++) req_wb[i] = mk(40 + i, 32'h4000 + i);
    tick();
    req_valid = '0;
    rst       = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    check("midrst_ready", 64'(req_ready), 64'hF);
    tick();
    check("midrst_nowrite", 64'(wp_wb[0].valid), 64'd0);
    req_valid = '1;
    for (int i = 0; i < NR; i++) req_wb[i] = mk(50 + i, 32'h6000 + i);
    tick();
    check("midrst_ptr0", 64'(wp_wb[0].wb_addr), 64'd50);
    req_valid = '0;
    repeat (3) tick();

    // Randomized traffic with hold-until-accepted requesters.
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < NR; i++) begin
        if (!(req_valid[i] && !last_acc[i])) begin
          req_valid[i] = ($urandom_range(0, 3) != 0);
          seq++;
          req_wb[i] = mk(($urandom_range(0, 15) == 0) ? 0 : 1 + (seq % 63), $urandom);
        end
      end
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/prf_wb_arbiter.md
# prf_wb_arbiter

Writeback arbiter sharing NUM_WP physical-register-file write ports among NUM_REQ functional-unit result streams in the Falco execute/writeback stage. Each requester owns a one-entry holding buffer with a valid/ready handshake. Occupied buffers are granted round-robin, up to NUM_WP per cycle. Granted entries drive the PRF write ports, which also serve as the issue-queue wakeup broadcast.

## Interface
Parameters:
- NUM_REQ, default 4: number of FU result streams (order 0 alu_csr_bc, 1 alu1, 2 muldiv, 3 mem).
- NUM_WP, default 2: PRF write ports; legal range 1..NUM_REQ.
- CNT_W, default 32: width of the stall counter.

Ports (reset rst, synchronous, active-high; clock clk):
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- req_valid  in  NUM_REQ  result offered by FU i.
- req_wb  in  NUM_REQ x exe_fu_wb_t  result payload; .valid ignored, wb_addr/wb_data used.
- req_ready  out  NUM_REQ  FU i result is accepted this cycle when valid&&ready.
- wp_wb  out  NUM_WP x exe_fu_wb_t  PRF write ports / wakeup broadcast.
- stall_cnt  out  CNT_W  saturating count of cycles with at least one occupied, ungranted buffer.

## Operation
- Per requester: buffer entry {occ, addr, data}.
- Accept rule: on valid&&ready with wb_addr!=0, load the buffer at the clock edge.
- Accept with wb_addr==0: handshake completes, the entry is dropped, no buffer is loaded, no port is used.
- Ready rule: req_ready[i] = !rst && (!occ[i] || grant[i]). A granted buffer can refill in the same cycle.
- No bypass: a request always passes through its buffer.
- Arbitration (combinational, from registered state): scan i = rr_ptr, rr_ptr+1, … mod NUM_REQ. The first NUM_WP occupied buffers are granted.
- Port assignment: the k-th grant in scan order drives wp_wb[k]. Unused ports have valid=0, addr=0, data=0.
- Pointer update: rr_ptr <= (index of last grant + 1) mod NUM_REQ. If there are no grants, rr_ptr is unchanged.
- Clear: a granted buffer clears occ at the edge unless it reloads in the same cycle.
- stall_cnt increments when any occ[i] && !grant[i]. It holds at 2^CNT_W-1 once saturated.
- Two granted entries with equal wb_addr is illegal because renaming guarantees unique destinations. This is checked by a simulation assertion only; no hardware resolution.

## Timing
- Latency: a result accepted at edge E appears on wp_wb in the cycle after E at the earliest. The PRF writes it at edge E+1.
- Throughput: NUM_WP writes per cycle. Each requester sustains 1 result/cycle while it wins every arbitration.
- Fairness: an occupied buffer is granted within ceil(NUM_REQ/NUM_WP) cycles. With the defaults, this is at most 2 cycles.
- Reset values: occ=0, rr_ptr=0, wp_wb all zero/invalid, req_ready=0 while rst=1, stall_cnt=0.
- Reset mid-operation: buffered results are discarded and nothing is written.
- Full: when all buffers are occupied and NUM_WP<NUM_REQ, ungranted requesters see ready=0 and must hold valid and payload stable.
- Empty: wp_wb stays invalid and rr_ptr holds.
- Wrap-around: the scan wraps from NUM_REQ-1 to 0 within a single cycle.

## Structure
- Falco_pkg: reuse exe_fu_wb_t, prf_specifier_t and xlen_data_t. Add constants WB_NUM_REQ=4 and WB_NUM_WP=2. Add index enum wb_req_e (WB_ALU_CSR_BC, WB_ALU1, WB_MULDIV, WB_MEM).
- Sub-module rr_multi_grant: combinational, parameterized NUM_REQ/NUM_WP.
  - Inputs: occ vector and rr_ptr.
  - Outputs: grant vector, per-port index/valid, next pointer.
- The top level holds buffers, pointer, counter and handshake.

## Test plan
- Reset: assert rst for 3 cycles with req_valid=4'b1111. Required: req_ready=0, wp_wb invalid, stall_cnt=0. After release, req_ready=4'b1111.
- Full contention: all 4 FUs offer results every cycle, addrs 10..13, rr_ptr=0.
  - Required grants: cycle 1 ports {0:addr10, 1:addr11}; cycle 2 {12, 13}; then alternating.
  - stall_cnt increments every cycle.
- Single requester: only muldiv offers addr 7, data 0xDEADBEEF. Required: wp_wb[0] = {1, 7, 0xDEADBEEF} one cycle after acceptance; wp_wb[1] invalid; stall_cnt unchanged.
- x0 drop: mem offers wb_addr=0. Required: accepted (ready=1), no wp_wb valid, occ stays 0.
- Back-to-back refill: alu1 streams addrs 20, 21, 22 on consecutive cycles with no contention. Required: ready stays 1 and the writes appear on three consecutive cycles.
- Reset mid-flight: 3 buffers occupied, then rst pulsed for 1 cycle. Required: no writes after the reset edge, rr_ptr=0, stall_cnt=0.
